// File: rtl/note_pkg.sv
// Shared note/scale definitions for the tone generator and the tuner.
// RATIO[n] is the pitch ratio of semitone n relative to A, scaled by 1000.
// half_of() gives the square-wave half-period in clock cycles for semitone n
// at octave 0 (A1 = 55 Hz), using 64-bit constant arithmetic.
package note_pkg;

  localparam int unsigned NOTES_PER_OCT = 12;
  localparam int unsigned MAX_IDX       = 36;
  localparam int unsigned BASE_FREQ     = 55;

  localparam int unsigned RATIO [NOTES_PER_OCT] = '{
    1000, 1059, 1122, 1189, 1260, 1335, 1414, 1498, 1587, 1682, 1782, 1888
  };

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  // floor(clk_hz * 500 / (55 * RATIO[n]))
  function automatic longint unsigned half_of(input longint unsigned clk_hz,
                                              input int unsigned      n);
    longint unsigned den;
    den = 64'(BASE_FREQ) * 64'(RATIO[n]);
    return (clk_hz * 64'd500) / den;
  endfunction

endpackage

// File: rtl/note_tone_gen_if.sv
// Request channel of the tone generator.
//   req_valid  : request present
//   req_ready  : generator can accept a request this cycle
//   req_note   : semitone 0..11 (0 = A)
//   req_octave : octave 0..3 above A1
//   req_mute   : stop the tone; note/octave ignored
interface note_tone_gen_if;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_note;
  logic [1:0] req_octave;
  logic       req_mute;

  modport master (output req_valid, req_note, req_octave, req_mute,
                  input  req_ready);
  modport slave  (input  req_valid, req_note, req_octave, req_mute,
                  output req_ready);
endinterface

// File: rtl/note_period_rom.sv
// Half-period lookup: 12-entry constant table derived from CLK_HZ, shifted
// right by the octave. One-cycle registered read.
//   clk    : system clock
//   note   : semitone 0..11 (values above 11 read as 0)
//   octave : octave 0..3
//   half   : registered half-period in clock cycles
module note_period_rom
  import note_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned CNT_W  = 24
) (
  input  logic             clk,
  input  logic [3:0]       note,
  input  logic [1:0]       octave,
  output logic [CNT_W-1:0] half
);

  localparam longint unsigned HZ = 64'(CLK_HZ);

  localparam longint unsigned HALF [NOTES_PER_OCT] = '{
    half_of(HZ, 0), half_of(HZ, 1), half_of(HZ, 2),  half_of(HZ, 3),
    half_of(HZ, 4), half_of(HZ, 5), half_of(HZ, 6),  half_of(HZ, 7),
    half_of(HZ, 8), half_of(HZ, 9), half_of(HZ, 10), half_of(HZ, 11)
  };

  // Shortest half-period must still give a usable square wave.
  if ((HALF[11] >> 3) < 64'd2) begin : g_min_half
    $error("note_period_rom: CLK_HZ too low, highest pitch half-period < 2");
  end

  // Longest half-period (A1) must fit the counter.
  if ((HALF[0] >> CNT_W) != 64'd0) begin : g_cnt_w
    $error("note_period_rom: CNT_W too narrow for the A1 half-period");
  end

  logic [63:0] base;

  always_comb begin
    base = '0;
    for (int unsigned i = 0; i < NOTES_PER_OCT; i++) begin
      if (note == 4'(i)) base = HALF[i];
    end
  end

  always_ff @(posedge clk) begin
    half <= CNT_W'(base >> octave);
  end

endmodule

// File: rtl/note_tone_gen.sv
// Square-wave reference tone generator, A1 (55 Hz) .. A4 (440 Hz).
// A request (note, octave or mute) is taken over the req channel; while a tone
// plays, a new request is held pending and applied only when a low phase
// ends, so no truncated pulse is ever emitted.
//   clk, rst   : clock, synchronous active-high reset
//   req        : request channel (slave side)
//   tone_out   : square-wave output
//   active     : tone currently running
//   cur_note   : note now playing
//   cur_octave : octave now playing
//   err        : one-cycle pulse when an invalid request is dropped
module note_tone_gen
  import note_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned CNT_W  = 24
) (
  input  logic            clk,
  input  logic            rst,
  note_tone_gen_if.slave  req,
  output logic            tone_out,
  output logic            active,
  output logic [3:0]      cur_note,
  output logic [1:0]      cur_octave,
  output logic            err
);

  state_t state_q, state_d;

  logic             ready_c;
  logic             accept;
  logic             req_ok;
  logic [5:0]       idx;
  logic             period_end;

  logic             pend_valid;
  logic             pend_mute;
  logic [3:0]       pend_note;
  logic [1:0]       pend_octave;

  logic [3:0]       rom_note;
  logic [1:0]       rom_octave;
  logic [3:0]       ld_note;
  logic [1:0]       ld_octave;
  logic [CNT_W-1:0] rom_half;
  logic [CNT_W-1:0] half_q;
  logic [CNT_W-1:0] cnt;

  assign idx    = 6'(req.req_octave) * 6'(NOTES_PER_OCT) + 6'(req.req_note);
  assign req_ok = (req.req_note < 4'(NOTES_PER_OCT)) && (idx <= 6'(MAX_IDX));
  assign accept = req.req_valid && ready_c;

  // End of a low phase: the cycle the output would otherwise rise.
  assign period_end = (state_q == RUN) && (cnt == '0) && !tone_out;

  // In IDLE the ROM is addressed straight from the request so LOAD can use it
  // on the next cycle; otherwise it tracks the pending request.
  assign rom_note   = (state_q == IDLE) ? req.req_note   : pend_note;
  assign rom_octave = (state_q == IDLE) ? req.req_octave : pend_octave;

  note_period_rom #(
    .CLK_HZ (CLK_HZ),
    .CNT_W  (CNT_W)
  ) u_rom (
    .clk    (clk),
    .note   (rom_note),
    .octave (rom_octave),
    .half   (rom_half)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept && !req.req_mute && req_ok) state_d = LOAD;
      LOAD:    state_d = RUN;
      RUN:     if (period_end && pend_valid) state_d = pend_mute ? IDLE : LOAD;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    ready_c = 1'b0;
    unique case (state_q)
      IDLE:    ready_c = 1'b1;
      RUN:     ready_c = !pend_valid;
      default: ready_c = 1'b0;
    endcase
  end

  assign req.req_ready = ready_c;

  // Datapath: pending request, counter, tone and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid  <= 1'b0;
      pend_mute   <= 1'b0;
      pend_note   <= '0;
      pend_octave <= '0;
      ld_note     <= '0;
      ld_octave   <= '0;
      half_q      <= '0;
      cnt         <= '0;
      tone_out    <= 1'b0;
      active      <= 1'b0;
      cur_note    <= '0;
      cur_octave  <= '0;
      err         <= 1'b0;
    end else begin
      // Mute never checks note/octave, so it can never be invalid.
      err <= accept && !req.req_mute && !req_ok;

      if (state_q != LOAD) begin
        ld_note   <= rom_note;
        ld_octave <= rom_octave;
      end

      if (period_end && pend_valid) begin
        pend_valid <= 1'b0;
      end else if (state_q == RUN && accept && (req.req_mute || req_ok)) begin
        pend_valid  <= 1'b1;
        pend_mute   <= req.req_mute;
        pend_note   <= req.req_note;
        pend_octave <= req.req_octave;
      end

      unique case (state_q)
        IDLE: begin
          tone_out <= 1'b0;
          active   <= 1'b0;
        end
        LOAD: begin
          half_q     <= rom_half;
          cnt        <= rom_half - 1'b1;
          tone_out   <= 1'b1;
          active     <= 1'b1;
          cur_note   <= ld_note;
          cur_octave <= ld_octave;
        end
        RUN: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (tone_out) begin
            tone_out <= 1'b0;
            cnt      <= half_q - 1'b1;
          end else if (pend_valid) begin
            // Retune stretches this low phase by the LOAD cycle; mute stops.
            tone_out <= 1'b0;
            active   <= !pend_mute;
          end else begin
            tone_out <= 1'b1;
            cnt      <= half_q - 1'b1;
          end
        end
        default: begin
          tone_out <= 1'b0;
          active   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/note_tone_gen.md
Name: note_tone_gen

Overview:
- Inverse of the tuner path: takes a requested note (semitone index plus octave) and produces a square-wave test tone at that pitch.
- Tone spans A1 (55 Hz) to A4 (440 Hz), using the same 37-step scale and ×1000 ratio table as the tuner.
- Used as a reference-pitch source and as loopback stimulus for the tuner.
- Frequency changes and mutes take effect only on full-period boundaries, so the output never carries a truncated pulse.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz.
- CNT_W, 24, half-period counter width; must hold the octave-0 A half-period (CLK_HZ*500/55000).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_note  in  4  semitone 0..11 (0=A, 1=A#, ... 11=G#).
- req_octave  in  2  octave 0..3 above A1.
- req_mute  in  1  1 = stop tone; note/octave ignored.
- tone_out  out  1  square-wave output.
- active  out  1  tone currently running.
- cur_note  out  4  note now playing.
- cur_octave  out  2  octave now playing.
- err  out  1  one-cycle pulse when an invalid request is dropped.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset: all outputs 0, except req_ready=1; state IDLE; pending cleared; counter 0.
- Handshake: transfer when req_valid && req_ready. req_ready=1 in IDLE; in RUN with no pending request; otherwise 0 (LOAD, or RUN with pending).
- Validity: idx = octave*12 + note. Invalid if note>11 or idx>36. Invalid requests are accepted, err pulses on the following cycle, state is unchanged.
- Half-period: HALF[n] = floor(CLK_HZ*500 / (55*RATIO[n])), evaluated with 64-bit constant arithmetic. half = HALF[note] >> octave. Octave 3 with note 0 gives A4. Elaboration error if HALF[11]>>3 < 2.
- IDLE: tone_out=0, active=0.
  - Valid non-mute accept at cycle T → LOAD at T+1 (registered ROM read, shift).
  - Mute accept in IDLE → no-op.
- LOAD: one cycle → RUN.
  - At T+2: tone_out=1, active=1, cur_note/cur_octave updated, counter=half-1.
- RUN:
  - Counter decrements each cycle.
  - At 0: toggle tone_out and reload half-1, giving exactly `half` cycles per level.
  - Accepted request is held as pending, never applied mid-period.
  - Pending is applied at the end of the low phase (the cycle tone_out would rise):
    - New tone: enters LOAD with tone_out held 0 for that extra cycle. The single stretched low phase is permitted.
    - Mute: enters IDLE, tone_out=0, active=0.
- Simultaneous events: rst has priority over everything. A new accept cannot coincide with pending, because ready=0 while pending.
- Reset mid-tone: tone_out drops to 0 on the next edge; pending is discarded.

Decomposition:
- Shared package note_pkg: RATIO[0..11] = 1000,1059,1122,1189,1260,1335,1414,1498,1587,1682,1782,1888; BASE_FREQ=55; NOTES_PER_OCT=12; MAX_IDX=36; state enum {IDLE, LOAD, RUN}. The tuner reuses RATIO and BASE_FREQ.
- Sub-module note_period_rom: 12-entry constant HALF table computed from CLK_HZ, registered 1-cycle read.

Test Plan (CLK_HZ=110_000, so HALF[0]=1000):
- Reset, then request note 0 octave 0 → tone_out rises 2 cycles after accept, then 1000 high / 1000 low repeating; active=1; cur_note=0.
- Request note 3 octave 0, then note 0 octave 2 → half-periods 841 and 250 cycles respectively.
- While running note 0 octave 0, request note 0 octave 1 mid-high-phase → req_ready=0 until the change. Current period completes 1000/1000, then one LOAD cycle, then 500/500.
- Request note 12 octave 0, and separately note 1 octave 3 → err pulses once each; tone and cur_* unchanged.
- Mute while running → the high and low phases finish, then active=0 and tone_out stays 0; req_ready=1.
- Assert rst mid-high-phase with a request pending → next cycle tone_out=0, active=0, req_ready=1; no tone resumes.
